// File: rtl/alu_exec.sv
// Execution stage: latches an opcode from the loader, collects one or two operands
// from the switch bus, then computes in one cycle (or iteratively for MUL) and holds the result.
module alu_exec #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_all_n,
   input  logic             instr_valid,
   input  logic [3:0]       instruction,
   input  logic [WIDTH-1:0] operand_in,
   input  logic             operand_load,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             result_valid,
   output logic             error,
   output logic [2:0]       state_dbg
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_A = 3'd1;
   localparam logic [2:0] S_LOAD_B = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MUL    = 3'd4;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   logic [2:0]         state_q,  state_d;
   logic [3:0]         op_q,     op_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SW-1:0]      cnt_q,    cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q,  carry_d;
   logic               zero_q,   zero_d;
   logic               rv_q,     rv_d;
   logic               error_q,  error_d;

   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [SW-1:0]      shamt;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic [2*WIDTH-1:0] acc_step;

   assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
   // The extra top bit of the difference is the borrow (A < B).
   assign diff_w = {1'b0, a_q} - {1'b0, b_q};
   assign shamt  = b_q[SW-1:0];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_q)
         OP_ADD: begin alu_res = sum_w[WIDTH-1:0];  alu_c = sum_w[WIDTH];  end
         OP_SUB: begin alu_res = diff_w[WIDTH-1:0]; alu_c = diff_w[WIDTH]; end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_NOT: alu_res = ~a_q;
         OP_SHL: alu_res = a_q << shamt;
         OP_SHR: alu_res = a_q >> shamt;
         default: alu_res = '0;
      endcase
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      rv_d     = 1'b0;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               if (instruction <= OP_MUL) begin
                  op_d    = instruction;
                  error_d = 1'b0;
                  state_d = S_LOAD_A;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_LOAD_A: begin
            if (operand_load) begin
               a_d     = operand_in;
               state_d = (op_q == OP_NOT) ? S_EXEC : S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            if (operand_load) begin
               b_d = operand_in;
               if (op_q == OP_MUL) begin
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a_q};
                  mplier_d = operand_in;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = (alu_res == '0);
            rv_d     = 1'b1;
            state_d  = S_IDLE;
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SW'(1);
            // Final iteration: publish the low half, flag any overflow into the high half.
            if (cnt_q == SW'(WIDTH - 1)) begin
               result_d = acc_step[WIDTH-1:0];
               carry_d  = |acc_step[2*WIDTH-1:WIDTH];
               zero_d   = (acc_step[WIDTH-1:0] == '0);
               rv_d     = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_all_n) begin
      if (!reset_all_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         rv_q     <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         rv_q     <= rv_d;
         error_q  <= error_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign result       = result_q;
   assign carry        = carry_q;
   assign zero         = zero_q;
   assign result_valid = rv_q;
   assign error        = error_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized bench for alu_exec: arithmetic reference model, expected-result queue,
// directed corner cases (carry/borrow, MUL overflow, NOT, illegal op, reset mid-MUL).
module tb_alu_exec;

   localparam int W  = 8;
   localparam int SW = $clog2(W);

   logic         clk = 1'b0;
   logic         reset_all_n;
   logic         instr_valid;
   logic [3:0]   instruction;
   logic [W-1:0] operand_in;
   logic         operand_load;
   logic         busy;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         result_valid;
   logic         error;
   logic [2:0]   state_dbg;

   alu_exec #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset_all_n  (reset_all_n),
      .instr_valid  (instr_valid),
      .instruction  (instruction),
      .operand_in   (operand_in),
      .operand_load (operand_load),
      .busy         (busy),
      .result       (result),
      .carry        (carry),
      .zero         (zero),
      .result_valid (result_valid),
      .error        (error),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int rv_seen  = 0;
   int rv_exp   = 0;

   logic [W+1:0] exp_q[$];
   logic [W-1:0] last_res;
   logic         last_c;
   logic         last_z;
   logic         exp_err;

   always @(negedge clk) if (reset_all_n && result_valid) rv_seen++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Returns {carry, zero, result} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input int op, input int a, input int b);
      longint m;
      longint r;
      logic   c;
      logic [W-1:0] rr;
      m = longint'(1) << W;
      c = 1'b0;
      r = 0;
      case (op)
         0: begin r = a + b; c = (r >= m); end
         1: begin r = (a - b + m) % m; c = (a < b); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (m - 1) - a;
         6: r = (longint'(a) * (longint'(1) << (b % (1 << SW)))) % m;
         7: r = a / (1 << (b % (1 << SW)));
         8: begin r = longint'(a) * longint'(b); c = (r >= m); end
         default: r = 0;
      endcase
      rr = W'(r % m);
      return {c, (rr == '0), rr};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_instr(input int op, input bit combo);
      instruction  = 4'(op);
      instr_valid  = 1'b1;
      operand_load = combo;
      operand_in   = W'($urandom);
      step();
      instr_valid  = 1'b0;
      operand_load = 1'b0;
   endtask

   task automatic load(input int v);
      operand_in   = W'(v);
      operand_load = 1'b1;
      step();
      operand_load = 1'b0;
   endtask

   task automatic idle_noise();
      repeat ($urandom_range(0, 2)) begin
         operand_in   = W'($urandom);
         operand_load = 1'($urandom_range(0, 1));
         step();
         operand_load = 1'b0;
      end
   endtask

   task automatic busy_noise();
      repeat ($urandom_range(0, 2)) begin
         instruction = 4'($urandom);
         instr_valid = 1'($urandom_range(0, 1));
         step();
         instr_valid = 1'b0;
      end
   endtask

   task automatic run_op(input int op, input int a, input int b, input bit noise, input bit combo);
      int lat;
      logic [W+1:0] e;
      if (noise) idle_noise();
      check("held_result", result, last_res);
      check("err_hold", error, exp_err);
      exp_q.push_back(model(op, a, b));
      send_instr(op, combo);
      exp_err = 1'b0;
      check("busy_load", busy, 1);
      check("err_clear", error, 0);
      if (combo) check("combo_strobe_dropped", state_dbg, 3'd1);
      if (noise) busy_noise();
      load(a);
      if (op == 5) begin
         check("not_skips_b", (state_dbg == 3'd2), 0);
      end else begin
         if (noise) busy_noise();
         load(b);
      end
      lat = 1;
      while (!result_valid && lat < W + 10) begin
         step();
         lat++;
      end
      check("latency", lat, (op == 8) ? W + 1 : 2);
      e = exp_q.pop_front();
      if (result_valid) rv_exp++;
      check("result", result, e[W-1:0]);
      check("carry", carry, e[W+1]);
      check("zero", zero, e[W]);
      check("busy_done", busy, 0);
      last_res = e[W-1:0];
      last_c   = e[W+1];
      last_z   = e[W];
      step();
      check("rv_one_cycle", result_valid, 0);
      check("held_after", {carry, zero, result}, {last_c, last_z, last_res});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset_all_n  = 1'b0;
      instr_valid  = 1'b0;
      instruction  = '0;
      operand_in   = '0;
      operand_load = 1'b0;
      last_res = '0; last_c = 1'b0; last_z = 1'b0; exp_err = 1'b0;
      step();
      step();
      check("rst_outputs", {busy, result_valid, error, carry, zero, result}, '0);
      reset_all_n = 1'b1;
      step();

      // Directed cases with literal expectations.
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
      check("add_ff_01", {carry, zero, result}, {1'b1, 1'b1, 8'h00});
      run_op(1, 8'h03, 8'h05, 1'b0, 1'b0);
      check("sub_03_05", {carry, zero, result}, {1'b1, 1'b0, 8'hFE});
      run_op(8, 8'h10, 8'h10, 1'b0, 1'b0);
      check("mul_10_10", {carry, result}, {1'b1, 8'h00});
      run_op(8, 7, 6, 1'b0, 1'b0);
      check("mul_7_6", {carry, zero, result}, {1'b0, 1'b0, 8'h2A});
      run_op(5, 8'h0F, 0, 1'b0, 1'b0);
      check("not_0f", {carry, zero, result}, {1'b0, 1'b0, 8'hF0});
      run_op(6, 8'h81, 9, 1'b0, 1'b0);
      check("shl_masked", result, 8'h02);
      run_op(7, 8'h80, 7, 1'b0, 1'b0);
      check("shr_7", result, 8'h01);

      // Illegal opcode: sticky error, stays idle, cleared by next legal op.
      send_instr(12, 1'b0);
      check("illegal_err", error, 1);
      check("illegal_idle", busy, 0);
      exp_err = 1'b1;
      step();
      check("illegal_sticky", error, 1);
      run_op(2, 8'hF0, 8'h3C, 1'b0, 1'b1);

      // Reset during MUL iteration 3 aborts with no result_valid.
      send_instr(8, 1'b0);
      load(8'h33);
      load(8'h55);
      step();
      step();
      step();
      check("mul_busy_pre_rst", busy, 1);
      reset_all_n = 1'b0;
      #1;
      check("rst_mid_mul", {busy, result_valid, error, carry, zero, result}, '0);
      step();
      step();
      reset_all_n = 1'b1;
      last_res = '0; last_c = 1'b0; last_z = 1'b0; exp_err = 1'b0;
      repeat (W + 2) begin
         step();
         check("no_rv_after_abort", result_valid, 0);
      end
      check("idle_after_abort", busy, 0);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            send_instr($urandom_range(9, 15), 1'b0);
            exp_err = 1'b1;
            check("rand_illegal_err", error, 1);
         end
         run_op($urandom_range(0, 8), $urandom_range(0, 255), $urandom_range(0, 255),
                1'b1, ($urandom_range(0, 3) == 0));
      end

      step();
      check("rv_total", rv_seen, rv_exp);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
